operator_ip_core: RTL and testbench
===================================

# operator_ip_core

Configurable three-operand arithmetic unit. It computes a 64-bit result `z` from three 32-bit operands `a`, `b`, `c`. The operation is selected by a software-writable OP_TYPE register reached through a simple write-only register port. It sits behind the register bus as a leaf compute IP; the result is registered and updates every cycle.

## Interface
Parameters:
- `OP_TYPE_ADDR`, default 10: register address of OP_TYPE.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: single clock, rising-edge active (500 MHz target).
- `rst`  in  1: synchronous reset, active-high.
- `reg_wr`  in  1: register write strobe, one-cycle qualifier.
- `reg_addr`  in  32: register write address.
- `reg_wr_data`  in  32: register write data.
- `a`  in  32: operand A, unsigned.
- `b`  in  32: operand B, unsigned.
- `c`  in  32: operand C, unsigned.
- `z`  out  64: registered result.

## Operation
- OP_TYPE register: 2 bits, reset value 0.
  - Written on a rising edge when `reg_wr`=1 and `reg_addr`==`OP_TYPE_ADDR`.
  - Stores `reg_wr_data[1:0]`; bits [31:2] are ignored.
  - Writes to any other address are silently dropped. No read path.
- Operand handling: operands are zero-extended to 64 bits. All arithmetic is modulo 2^64 (two's-complement wrap, no saturation, no flags).
- Operation select:
  - 0: z = 0 (idle).
  - 1: z = a + b − c.
  - 2: z = a − b − c.
  - 3: z = a × b + c (full 64-bit product plus c).
- Negative results appear as 64-bit two's complement. Example: op 2, a=10, b=50, c=10 → z = 2^64 − 50.
- `reg_wr` held for several cycles rewrites the same value each cycle; this has no side effect.

## Timing
- Reset: while `rst`=1 at a rising edge, OP_TYPE←0 and z←0. Reset has priority over a simultaneous register write. Reset mid-operation clears z on that same edge.
- Register write latency:
  - OP_TYPE updates on the edge where the write is sampled.
  - The new operation is first applied to z at the next edge (1-cycle write-to-effect).
- Compute latency: z at edge N+1 reflects `a`, `b`, `c` and OP_TYPE as sampled at edge N (1-cycle registered output).
- Simultaneous write and operand change at edge N:
  - z at N uses the old OP_TYPE.
  - z at N+1 uses the new OP_TYPE with the operands present at N+1.
- z holds its computed value while inputs are stable and recomputes every cycle. There is no valid/handshake signal.
- Multiplier path (op 3) must close timing in one cycle at the target clock, or the implementation must document a retimed multiplier that keeps the 1-cycle latency for all ops.

## Test plan
- Reset: hold `rst`=1 for 5 cycles with arbitrary a/b/c → z=0 throughout. After release with no write (OP_TYPE=0) → z stays 0.
- Op 1: write 1 to addr 10; apply a=100, b=50, c=10 → z=140 one cycle after operands are stable.
- Op 2: write 2 to addr 10; apply a=100, b=50, c=10 → z=40. Then a=10, b=50, c=10 → z=0xFFFF_FFFF_FFFF_FFCE.
- Op 3 and width:
  - Write 3; a=b=0xFFFF_FFFF, c=1 → z=0xFFFF_FFFE_0000_0002.
  - Write 1; a=b=0xFFFF_FFFF, c=0 → z=0x1_FFFF_FFFE (carry kept).
- Address decode: with OP_TYPE=1, write 2 to addr 11 → z still a+b−c. Write 0x0000_0006 to addr 10 → op 2 selected (upper bits ignored).
- Reset priority: assert `rst` and a write of 1 to addr 10 on the same edge → OP_TYPE=0, z=0 on following cycles.

Source files
------------

// File: rtl/operator_ip_core.sv
`default_nettype none
// ============================================================================
// Module   : operator_ip_core
// Brief    : Three-operand 64-bit arithmetic unit; operation picked by OP_TYPE.
// Revision : 1.0
// ============================================================================
module operator_ip_core #(
  parameter int unsigned OP_TYPE_ADDR = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [31:0] reg_addr,
  input  logic [31:0] reg_wr_data,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [63:0] z
);

  localparam logic [31:0] c_OP_ADDR  = 32'(OP_TYPE_ADDR);
  localparam logic [1:0]  c_OP_IDLE  = 2'd0;
  localparam logic [1:0]  c_OP_ADDSB = 2'd1;
  localparam logic [1:0]  c_OP_SUBSB = 2'd2;
  localparam logic [1:0]  c_OP_MAC   = 2'd3;

  logic [1:0]  op_q, op_d;
  logic [63:0] z_q, z_d;
  logic [63:0] w_a_ext, w_b_ext, w_c_ext;
  logic        w_unused;

  // Only the low two data bits carry meaning.
  assign w_unused = ^reg_wr_data[31:2];

  assign w_a_ext = {32'd0, a};
  assign w_b_ext = {32'd0, b};
  assign w_c_ext = {32'd0, c};

  always_comb begin
    op_d = op_q;
    if (reg_wr && (reg_addr == c_OP_ADDR)) begin
      op_d = reg_wr_data[1:0];
    end
  end

  // z uses the OP_TYPE already held, so a write takes effect one edge later.
  // The 32x32 product maps onto hard multiplier blocks in a single stage.
  always_comb begin
    z_d = 64'd0;
    case (op_q)
      c_OP_IDLE:  z_d = 64'd0;
      c_OP_ADDSB: z_d = w_a_ext + w_b_ext - w_c_ext;
      c_OP_SUBSB: z_d = w_a_ext - w_b_ext - w_c_ext;
      c_OP_MAC:   z_d = (w_a_ext * w_b_ext) + w_c_ext;
      default:    z_d = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= c_OP_IDLE;
      z_q  <= 64'd0;
    end else begin
      op_q <= op_d;
      z_q  <= z_d;
    end
  end

  assign z = z_q;

endmodule
`default_nettype wire

// File: tb/tb_operator_ip_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_operator_ip_core
// Brief    : Directed plus random checks of operator_ip_core against a model.
// Revision : 1.0
// ============================================================================
module tb_operator_ip_core;

  localparam int unsigned c_ADDR = 10;

  logic        clk;
  logic        rst;
  logic        reg_wr;
  logic [31:0] reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] a, b, c;
  logic [63:0] z;

  int          errors;
  int          checks;
  int unsigned model_op;
  longint unsigned exp_z;

  operator_ip_core #(.OP_TYPE_ADDR(c_ADDR)) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .a           (a),
    .b           (b),
    .c           (c),
    .z           (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint unsigned ref_z(input int unsigned op,
                                            input logic [31:0] ia,
                                            input logic [31:0] ib,
                                            input logic [31:0] ic);
    longint unsigned xa, xb, xc;
    xa = longint'(ia);
    xb = longint'(ib);
    xc = longint'(ic);
    case (op)
      1:       return xa + xb - xc;
      2:       return xa - xb - xc;
      3:       return xa * xb + xc;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] expv);
    checks++;
    assert (z === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, z, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic cyc(input logic ir, input logic iw, input logic [31:0] iad,
                     input logic [31:0] idat, input logic [31:0] ia,
                     input logic [31:0] ib, input logic [31:0] ic,
                     input string tag);
    rst = ir; reg_wr = iw; reg_addr = iad; reg_wr_data = idat;
    a = ia; b = ib; c = ic;
    @(posedge clk);
    if (ir) begin
      exp_z    = 64'd0;
      model_op = 0;
    end else begin
      exp_z = ref_z(model_op, ia, ib, ic);
      if (iw && iad == c_ADDR) model_op = int'(idat[1:0]);
    end
    #1;
    check(tag, exp_z);
  endtask

  initial begin
    errors = 0; checks = 0; model_op = 0; exp_z = 0;
    rst = 1'b1; reg_wr = 1'b0; reg_addr = '0; reg_wr_data = '0;
    a = '0; b = '0; c = '0;

    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, $urandom, $urandom, $urandom, "reset_hold");
    check("reset_zero", 64'd0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, $urandom, $urandom, $urandom, "idle_after_reset");
    check("idle_zero", 64'd0);

    cyc(0, 1, 10, 1, 100, 50, 10, "op1_write");
    cyc(0, 0, 0, 0, 100, 50, 10, "op1_calc");
    check("op1_140", 64'd140);

    cyc(0, 1, 10, 2, 100, 50, 10, "op2_write");
    cyc(0, 0, 0, 0, 100, 50, 10, "op2_calc");
    check("op2_40", 64'd40);
    cyc(0, 0, 0, 0, 10, 50, 10, "op2_neg");
    check("op2_neg_const", 64'hFFFF_FFFF_FFFF_FFCE);

    cyc(0, 1, 10, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "op3_write");
    cyc(0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "op3_calc");
    check("op3_max", 64'hFFFF_FFFE_0000_0002);

    cyc(0, 1, 10, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "op1_carry_write");
    cyc(0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "op1_carry");
    check("op1_carry_const", 64'h0000_0001_FFFF_FFFE);

    cyc(0, 1, 11, 2, 100, 50, 10, "wrong_addr_write");
    cyc(0, 0, 0, 0, 100, 50, 10, "wrong_addr_calc");
    check("wrong_addr_keeps_op1", 64'd140);
    cyc(0, 1, 10, 32'h0000_0006, 100, 50, 10, "upper_bits_write");
    cyc(0, 0, 0, 0, 100, 50, 10, "upper_bits_calc");
    check("upper_bits_op2", 64'd40);

    cyc(0, 1, 10, 3, 7, 6, 5, "held_wr_1");
    cyc(0, 1, 10, 3, 7, 6, 5, "held_wr_2");
    cyc(0, 1, 10, 3, 7, 6, 5, "held_wr_3");
    check("held_wr_op3", 64'd47);

    cyc(1, 1, 10, 1, 100, 50, 10, "rst_priority");
    check("rst_priority_zero", 64'd0);
    cyc(0, 0, 0, 0, 100, 50, 10, "after_rst_1");
    cyc(0, 0, 0, 0, 100, 50, 10, "after_rst_2");
    check("after_rst_zero", 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_wr;
      logic [31:0] r_addr, r_a, r_b, r_c;
      r_rst  = ($urandom_range(0, 31) == 0);
      r_wr   = ($urandom_range(0, 3) == 0);
      r_addr = ($urandom_range(0, 3) != 0) ? 32'd10 : $urandom;
      r_a    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      r_b    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      r_c    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      cyc(r_rst, r_wr, r_addr, $urandom, r_a, r_b, r_c, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
